// File: rtl/stream_arb_2to1.sv
// rtl/stream_arb_2to1.sv - two-requester stream arbiter with a registered shared output stage
// Optional packet lock: define STREAM_ARB_PKT_LOCK_EN to keep a requester granted until its last beat.
module stream_arb_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             out_src
);

  // ptr = 0 prefers in0 on contention, ptr = 1 prefers in1
  logic             ptr;
  logic             load_en;
  logic             pick0;
  logic             pick1;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             win_src;
  logic             win_last;
  logic [WIDTH-1:0] win_data;

`ifdef STREAM_ARB_PKT_LOCK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_t;

  lock_state_t state;
  lock_state_t state_next;
`endif

  // The output register can take a new beat when empty or being drained this cycle
  assign load_en = !out_valid || out_ready;

  // Free arbitration: a lone requester wins, contention is settled by ptr
  assign pick0 = in0_valid && (!in1_valid || !ptr);
  assign pick1 = in1_valid && (!in0_valid || ptr);

  // Grant selection; under packet lock the owner is the only candidate
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef STREAM_ARB_PKT_LOCK_EN
    case (state)
      LOCK0:   grant0 = in0_valid;
      LOCK1:   grant1 = in1_valid;
      default: begin
        grant0 = pick0;
        grant1 = pick1;
      end
    endcase
`else
    grant0 = pick0;
    grant1 = pick1;
`endif
  end

  // Readies are forced low during reset so nothing is consumed while rst is high
  assign in0_ready = !rst && load_en && grant0;
  assign in1_ready = !rst && load_en && grant1;

  // A grant implies the granted requester is valid, so either ready means a transfer
  assign accept   = in0_ready || in1_ready;
  assign win_src  = in1_ready;
  assign win_data = win_src ? in1_data : in0_data;
  assign win_last = win_src ? in1_last : in0_last;

  // Output stage: load on accept, empty when free with nothing accepted, hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (load_en) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_last  <= win_last;
        out_data  <= win_data;
        out_src   <= win_src;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Priority pointer moves to the non-winner at each grant boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
`ifdef STREAM_ARB_PKT_LOCK_EN
    end else if (accept && win_last) begin
`else
    end else if (accept) begin
`endif
      ptr <= !win_src;
    end
  end

`ifdef STREAM_ARB_PKT_LOCK_EN
  // Lock state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Enter or stay locked on a non-last beat, release on the owner's last beat
  always_comb begin
    state_next = state;
    if (accept) begin
      if (win_last) begin
        state_next = IDLE;
      end else begin
        state_next = win_src ? LOCK1 : LOCK0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_arb_2to1.sv
// tb/tb_stream_arb_2to1.sv - scoreboard bench for stream_arb_2to1 with a queue-level reference model
module tb_stream_arb_2to1;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in0_data = '0, in1_data = '0;
  logic         in0_valid = 1'b0, in1_valid = 1'b0;
  logic         in0_last = 1'b0, in1_last = 1'b0;
  logic         in0_ready, in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid, out_last, out_src;
  logic         out_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  // Expected beats {src, last, data} in acceptance order; observed beats {src, data}
  logic [W+1:0] exp_q[$];
  logic [W:0]   seen[$];
  logic [W+1:0] mon_e;

  // Reference model: is a beat sitting in the output slot, who is preferred, who owns a packet
  bit m_valid;
  int m_pref;
  int m_owner;
`ifdef STREAM_ARB_PKT_LOCK_EN
  bit lock_mode = 1'b1;
`else
  bit lock_mode = 1'b0;
`endif

  stream_arb_2to1 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_data  (in0_data),
    .in0_valid (in0_valid),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_data  (in1_data),
    .in1_valid (in1_valid),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every output handshake pops one expected beat
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_beat: got %0h expected no beat", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data, mon_e[W-1:0]);
        chk("out_last", out_last, mon_e[W]);
        chk("out_src", out_src, mon_e[W+1]);
      end
      seen.push_back({out_src, out_data});
    end
  end

  // One clock of stimulus; entered and left at posedge+2
  task automatic cycle(input bit v0, input logic [W-1:0] d0, input bit l0,
                       input bit v1, input logic [W-1:0] d1, input bit l1,
                       input bit ordy, output int win);
    bit           load;
    bit           blast;
    logic [W-1:0] bdata;
    in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1;
    out_ready = ordy;
    #1;
    chk("out_valid", out_valid, m_valid);
    load = !m_valid || ordy;
    win = -1;
    if (load) begin
      if (m_owner >= 0) begin
        if ((m_owner == 0) ? v0 : v1) win = m_owner;
      end else if (v0 && v1) begin
        win = m_pref;
      end else if (v0) begin
        win = 0;
      end else if (v1) begin
        win = 1;
      end
    end
    chk("in0_ready", in0_ready, win == 0);
    chk("in1_ready", in1_ready, win == 1);
    if (win >= 0) begin
      blast = (win == 0) ? l0 : l1;
      bdata = (win == 0) ? d0 : d1;
      exp_q.push_back({win == 1, blast, bdata});
      m_valid = 1'b1;
      if (!lock_mode || blast) begin
        m_pref  = 1 - win;
        m_owner = -1;
      end else begin
        m_owner = win;
      end
    end else if (load) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst = 1'b1;
      in0_valid = 1'b1; in1_valid = 1'b1;
      in0_data = W'($urandom); in1_data = W'($urandom);
      out_ready = 1'b1;
      #1;
      chk("rst_in0_ready", in0_ready, 0);
      chk("rst_in1_ready", in1_ready, 0);
      @(posedge clk);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_src", out_src, 0);
    end
    exp_q.delete();
    m_valid = 1'b0;
    m_pref  = 0;
    m_owner = -1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int w;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(0, '0, 0, 0, '0, 0, 1, w);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  function automatic void chk_seen(input string name, input int idx, input logic [W:0] exp);
    if (idx < seen.size()) begin
      chk(name, seen[idx], exp);
    end else begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: got no beat %0d expected %0h", name, idx, exp);
    end
  endfunction

  initial begin
    int           w;
    int           idx;
    logic [W-1:0] pkt [3];
    logic [W:0]   lock_exp [4];

    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    m_valid = 1'b0; m_pref = 0; m_owner = -1;
    @(posedge clk);
    #2;

    // Two reset cycles with both requesters valid, then contention at full rate
    do_reset(2);
    seen.delete();
    repeat (4) cycle(1, 8'hAA, 1, 1, 8'h55, 1, 1, w);
    drain();
    chk_seen("cont_beat0", 0, {1'b0, 8'hAA});
    chk_seen("cont_beat1", 1, {1'b1, 8'h55});
    chk_seen("cont_beat2", 2, {1'b0, 8'hAA});
    chk_seen("cont_beat3", 3, {1'b1, 8'h55});

    // Backpressure holds the output and blocks both requesters
    do_reset(1);
    cycle(1, 8'hAA, 1, 0, '0, 0, 1, w);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'hBB, 1, 1, 8'hCC, 1, 0, w);
      chk("bp_hold_data", out_data, 8'hAA);
      chk("bp_hold_valid", out_valid, 1);
    end
    cycle(1, 8'hBB, 1, 0, '0, 0, 1, w);
    chk("bp_next_data", out_data, 8'hBB);
    drain();

    // Multi-beat packet on in0 against a steady in1
    do_reset(1);
    seen.delete();
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(idx < 3, (idx < 3) ? pkt[idx] : 8'h00, idx == 2, 1, 8'h77, 1, 1, w);
      if (w == 0) idx++;
    end
    drain();
    if (lock_mode) begin
      lock_exp[0] = {1'b0, 8'h11}; lock_exp[1] = {1'b0, 8'h22};
      lock_exp[2] = {1'b0, 8'h33}; lock_exp[3] = {1'b1, 8'h77};
    end else begin
      lock_exp[0] = {1'b0, 8'h11}; lock_exp[1] = {1'b1, 8'h77};
      lock_exp[2] = {1'b0, 8'h22}; lock_exp[3] = {1'b1, 8'h77};
    end
    for (int i = 0; i < 4; i++) chk_seen("pkt_beat", i, lock_exp[i]);

    // Single requester, then idle: valid drops, data holds
    do_reset(1);
    cycle(0, '0, 0, 1, 8'hC3, 1, 1, w);
    chk("single_data", out_data, 8'hC3);
    chk("single_src", out_src, 1);
    chk("single_valid", out_valid, 1);
    cycle(0, '0, 0, 0, '0, 0, 1, w);
    chk("idle_valid", out_valid, 0);
    chk("idle_hold_data", out_data, 8'hC3);

    // Reset in the middle of an in0 packet; afterwards arbitration is fresh
    for (int v = 0; v < 2; v++) begin
      do_reset(1);
      cycle(1, 8'h11, 0, 0, '0, 0, 1, w);
      cycle(1, 8'h22, 0, 0, '0, 0, 1, w);
      do_reset(1);
      if (v == 0) begin
        cycle(1, 8'hA1, 1, 1, 8'hB2, 1, 1, w);
        chk("post_rst_src", out_src, 0);
        chk("post_rst_data", out_data, 8'hA1);
      end else begin
        cycle(0, '0, 0, 1, 8'hB2, 1, 1, w);
        chk("post_rst_unlocked_src", out_src, 1);
        chk("post_rst_unlocked_data", out_data, 8'hB2);
      end
      drain();
    end

    // Randomized traffic with occasional resets
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1 + $urandom_range(0, 1));
      end else begin
        cycle($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 4,
              $urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 4,
              $urandom_range(0, 3) != 0, w);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
